tpu_tile_sched: RTL and testbench
=================================

// Module: tpu_tile_sched
// PURPOSE
//  Central sequencer for the TPU: latches a job (K,M,N), walks output tiles of a PxP
//  systolic array, issues A/B buffer read indices, controls PE clear/feed, and writes C rows.
//  Sits between the top-level handshake (in_valid/busy) and the array + global buffers.
//  Computes C[MxN] = A[MxK] * B[KxN]. A word = P int8 rows at one k; B word = P int8 cols at one k.
// PARAMETERS
//  P         4   systolic array dimension (rows = cols)
//  DIM_W     8   width of K, M, N
//  IDX_W    16   width of A/B/C buffer indices
//  RD_LAT    1   global-buffer read latency, in cycles
// PORTS
//  clk        in   1      system clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      job start pulse; K/M/N are valid in the same cycle
//  K,M,N      in   DIM_W  job dimensions
//  busy       out  1      high while a job is in progress
//  A_wr_en    out  1      tied 0 (this block only reads A)
//  A_index    out  IDX_W  A read index = mt*K + k
//  B_wr_en    out  1      tied 0 (this block only reads B)
//  B_index    out  IDX_W  B read index = nt*K + k
//  pe_clear   out  1      1-cycle pulse that zeroes all PE accumulators
//  feed_valid out  1      A/B data_out is valid this cycle; array consumes and skews it
//  C_wr_en    out  1      C write strobe
//  C_index    out  IDX_W  C index = nt*M + mt*P + r
//  c_row_sel  out  clog2P array row routed to C_data_in
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, all counters 0. Reset mid-job aborts with no further writes.
//  MT=ceil(M/P), NT=ceil(N/P). Tile order: nt outer, mt inner.
//  FSM: IDLE -> LOAD -> CLEAR -> FEED -> DRAIN -> WRITE -> (next tile ? CLEAR : IDLE)
//   IDLE : busy=0. in_valid=1 -> LOAD; latch K,M,N.
//   LOAD : 1 cycle; compute MT, NT; clear mt, nt. Any of K,M,N = 0 -> IDLE with no reads or writes.
//   CLEAR: 1 cycle; pe_clear=1; k=0.
//   FEED : K cycles; A_index/B_index use k=0..K-1, one per cycle.
//          feed_valid is the FEED-cycle flag delayed by RD_LAT.
//   DRAIN: 2*(P-1)+RD_LAT cycles; no reads; flushes the skew wavefront.
//   WRITE: P cycles, r=0..P-1; c_row_sel=r; C_index=nt*M+mt*P+r;
//          C_wr_en = (mt*P+r < M). Rows past M are masked; columns past N are written
//          as-is (the buffer word holds P cols, and the datapath zero-pads B).
//  busy=1 in every state except IDLE. It rises on the edge that samples in_valid and falls
//  on the edge after the last WRITE cycle.
//  Latency (no zero dimension): busy cycles = 1 + MT*NT*(1 + K + 2P-2+RD_LAT + P);
//  for P=4, RD_LAT=1 this is 1 + MT*NT*(K+12).
//  in_valid while busy=1 is ignored; K/M/N changes while busy do not affect the job.
//  in_valid in the first IDLE cycle after a job is accepted (back-to-back jobs allowed).
//  Index arithmetic uses IDX_W unsigned. Worst case 63*255+255 < 2^16, so no overflow.
//  Use running adders (idx += K per tile step), not multipliers.
//  A_index/B_index hold their last value outside FEED. C_index and c_row_sel are 0 outside WRITE.
// STRUCTURE
//  tpu_pkg: P, DIM_W, IDX_W, RD_LAT, state enum (IDLE/LOAD/CLEAR/FEED/DRAIN/WRITE), clog2P.
//  Sub-module tpu_addr_gen: owns the k, r, mt, nt counters and the running A/B/C base adders.
//  It receives step/clear strobes from the FSM in tpu_tile_sched and returns last-k, last-r
//  and last-tile flags.
// TESTING
//  1 K=M=N=4 -> A_index 0..3 and B_index 0..3 in FEED; feed_valid 1 cycle later;
//    C_index 0..3 with C_wr_en=1; busy high exactly 17 cycles.
//  2 K=2,M=6,N=4 -> tile mt=0 writes C 0..3; tile mt=1: A_index 2,3, C_index 4,5 written,
//    rows 6,7 masked (C_wr_en=0); busy=29.
//  3 K=3,M=4,N=8 -> nt=1 tile: B_index 3..5, C_index 4..7; pe_clear pulses twice; busy=31.
//  4 K=0,M=4,N=4 -> busy high 1 cycle; no pe_clear, feed_valid or C_wr_en.
//  5 in_valid pulsed during FEED with new K -> ignored, original job completes unchanged.
//    Then in_valid on the first idle cycle -> new job starts on the next cycle.
//  6 rst_n low during DRAIN of K=M=N=8 -> all outputs 0 immediately (async);
//    no C_wr_en after release; a new job then runs correctly.

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared constants, state encoding and helpers for the TPU tile sequencer.
// P must be a power of two; tile counts are derived with a shift.
package tpu_pkg;

    localparam int P         = 4;
    localparam int DIM_W     = 8;
    localparam int IDX_W     = 16;
    localparam int RD_LAT    = 1;
    localparam int CLOG2P    = $clog2(P);
    localparam int DRAIN_LEN = 2 * (P - 1) + RD_LAT;
    localparam int DRAIN_W   = $clog2(DRAIN_LEN + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CLEAR,
        FEED,
        DRAIN,
        WRITE
    } state_t;

    // Number of P-wide tiles needed to cover a dimension, i.e. ceil(d / P).
    function automatic logic [DIM_W-1:0] ceil_div_p(input logic [DIM_W-1:0] d);
        logic [DIM_W:0] s;
        s = {1'b0, d} + (DIM_W + 1)'(P - 1);
        return DIM_W'(s >> CLOG2P);
    endfunction

endpackage

// File: rtl/tpu_addr_gen.sv
// Tile/k/row counters and running base adders for the A, B and C buffer indices.
// A/B read indices are registers so they hold their last value outside FEED.
module tpu_addr_gen
    import tpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              tile_start,
    input  logic              k_step,
    input  logic              r_step,
    input  logic [DIM_W-1:0]  k_dim,
    input  logic [DIM_W-1:0]  m_dim,
    input  logic [DIM_W-1:0]  n_dim,
    output logic [IDX_W-1:0]  a_index,
    output logic [IDX_W-1:0]  b_index,
    output logic [IDX_W-1:0]  c_index,
    output logic [CLOG2P-1:0] row,
    output logic              row_ok,
    output logic              last_k,
    output logic              last_r,
    output logic              last_tile
);

    logic [DIM_W-1:0]  k_reg;
    logic [CLOG2P-1:0] r_reg;
    logic [DIM_W-1:0]  mt_reg;
    logic [DIM_W-1:0]  nt_reg;
    logic [DIM_W-1:0]  mt_cnt_reg;
    logic [DIM_W-1:0]  nt_cnt_reg;
    logic [IDX_W-1:0]  a_base_reg;
    logic [IDX_W-1:0]  b_base_reg;
    logic [IDX_W-1:0]  c_base_reg;
    logic [IDX_W-1:0]  c_col_base_reg;
    logic [IDX_W-1:0]  row_base_reg;
    logic [IDX_W-1:0]  a_idx_reg;
    logic [IDX_W-1:0]  b_idx_reg;

    logic [IDX_W-1:0]  k_ext;
    logic [IDX_W-1:0]  m_ext;
    logic              last_mt;
    logic              last_nt;
    logic              tile_step;

    assign k_ext     = IDX_W'(k_dim);
    assign m_ext     = IDX_W'(m_dim);
    assign last_k    = (k_reg == k_dim - DIM_W'(1));
    assign last_r    = (r_reg == CLOG2P'(P - 1));
    assign last_mt   = (mt_reg == mt_cnt_reg - DIM_W'(1));
    assign last_nt   = (nt_reg == nt_cnt_reg - DIM_W'(1));
    assign last_tile = last_mt & last_nt;
    assign tile_step = r_step & last_r;

    assign a_index = a_idx_reg;
    assign b_index = b_idx_reg;
    assign c_index = c_base_reg + IDX_W'(r_reg);
    assign row     = r_reg;
    assign row_ok  = ((row_base_reg + IDX_W'(r_reg)) < m_ext);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_reg          <= '0;
            r_reg          <= '0;
            mt_reg         <= '0;
            nt_reg         <= '0;
            mt_cnt_reg     <= '0;
            nt_cnt_reg     <= '0;
            a_base_reg     <= '0;
            b_base_reg     <= '0;
            c_base_reg     <= '0;
            c_col_base_reg <= '0;
            row_base_reg   <= '0;
            a_idx_reg      <= '0;
            b_idx_reg      <= '0;
        end else if (load) begin
            k_reg          <= '0;
            r_reg          <= '0;
            mt_reg         <= '0;
            nt_reg         <= '0;
            mt_cnt_reg     <= ceil_div_p(m_dim);
            nt_cnt_reg     <= ceil_div_p(n_dim);
            a_base_reg     <= '0;
            b_base_reg     <= '0;
            c_base_reg     <= '0;
            c_col_base_reg <= '0;
            row_base_reg   <= '0;
        end else begin
            if (tile_start) begin
                k_reg     <= '0;
                a_idx_reg <= a_base_reg;
                b_idx_reg <= b_base_reg;
            end else if (k_step) begin
                k_reg <= last_k ? '0 : k_reg + DIM_W'(1);
                if (!last_k) begin
                    a_idx_reg <= a_idx_reg + IDX_W'(1);
                    b_idx_reg <= b_idx_reg + IDX_W'(1);
                end
            end

            if (r_step) begin
                r_reg <= last_r ? '0 : r_reg + CLOG2P'(1);
            end

            // mt is the inner loop: wrap it and advance nt at the last row tile
            if (tile_step) begin
                if (last_mt) begin
                    mt_reg         <= '0;
                    nt_reg         <= nt_reg + DIM_W'(1);
                    a_base_reg     <= '0;
                    b_base_reg     <= b_base_reg + k_ext;
                    c_col_base_reg <= c_col_base_reg + m_ext;
                    c_base_reg     <= c_col_base_reg + m_ext;
                    row_base_reg   <= '0;
                end else begin
                    mt_reg       <= mt_reg + DIM_W'(1);
                    a_base_reg   <= a_base_reg + k_ext;
                    c_base_reg   <= c_base_reg + IDX_W'(P);
                    row_base_reg <= row_base_reg + IDX_W'(P);
                end
            end
        end
    end

endmodule

// File: rtl/tpu_tile_sched.sv
// Job sequencer: walks output tiles (nt outer, mt inner) through clear/feed/drain/write
// phases, driving buffer read indices, PE control and masked C row writes.
module tpu_tile_sched
    import tpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DIM_W-1:0]  K,
    input  logic [DIM_W-1:0]  M,
    input  logic [DIM_W-1:0]  N,
    output logic              busy,
    output logic              A_wr_en,
    output logic [IDX_W-1:0]  A_index,
    output logic              B_wr_en,
    output logic [IDX_W-1:0]  B_index,
    output logic              pe_clear,
    output logic              feed_valid,
    output logic              C_wr_en,
    output logic [IDX_W-1:0]  C_index,
    output logic [CLOG2P-1:0] c_row_sel
);

    state_t             state_reg;
    state_t             state_next;
    logic [DIM_W-1:0]   job_k_reg;
    logic [DIM_W-1:0]   job_m_reg;
    logic [DIM_W-1:0]   job_n_reg;
    logic [DRAIN_W-1:0] drain_cnt_reg;
    logic [RD_LAT-1:0]  feed_pipe_reg;

    logic               load;
    logic               tile_start;
    logic               k_step;
    logic               r_step;
    logic               drain_done;
    logic [IDX_W-1:0]   c_index_raw;
    logic [CLOG2P-1:0]  row;
    logic               row_ok;
    logic               last_k;
    logic               last_r;
    logic               last_tile;

    tpu_addr_gen u_addr_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .tile_start (tile_start),
        .k_step     (k_step),
        .r_step     (r_step),
        .k_dim      (job_k_reg),
        .m_dim      (job_m_reg),
        .n_dim      (job_n_reg),
        .a_index    (A_index),
        .b_index    (B_index),
        .c_index    (c_index_raw),
        .row        (row),
        .row_ok     (row_ok),
        .last_k     (last_k),
        .last_r     (last_r),
        .last_tile  (last_tile)
    );

    assign drain_done = (drain_cnt_reg == DRAIN_W'(DRAIN_LEN - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            job_k_reg     <= '0;
            job_m_reg     <= '0;
            job_n_reg     <= '0;
            drain_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && in_valid) begin
                job_k_reg <= K;
                job_m_reg <= M;
                job_n_reg <= N;
            end
            drain_cnt_reg <= (state_reg == DRAIN) ? drain_cnt_reg + DRAIN_W'(1) : '0;
        end
    end

    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        tile_start = 1'b0;
        k_step     = 1'b0;
        r_step     = 1'b0;
        pe_clear   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (in_valid) state_next = LOAD;
            end
            LOAD: begin
                load = 1'b1;
                if (job_k_reg == '0 || job_m_reg == '0 || job_n_reg == '0)
                    state_next = IDLE;
                else
                    state_next = CLEAR;
            end
            CLEAR: begin
                pe_clear   = 1'b1;
                tile_start = 1'b1;
                state_next = FEED;
            end
            FEED: begin
                k_step = 1'b1;
                if (last_k) state_next = DRAIN;
            end
            DRAIN: begin
                if (drain_done) state_next = WRITE;
            end
            WRITE: begin
                r_step = 1'b1;
                if (last_r) state_next = last_tile ? IDLE : CLEAR;
            end
            default: state_next = IDLE;
        endcase
    end

    // feed_valid trails the FEED phase by the buffer read latency
    generate
        for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_feed_pipe
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    feed_pipe_reg[gi] <= 1'b0;
                end else if (gi == 0) begin
                    feed_pipe_reg[gi] <= (state_reg == FEED);
                end else begin
                    feed_pipe_reg[gi] <= feed_pipe_reg[(gi == 0) ? 0 : gi - 1];
                end
            end
        end
    endgenerate

    assign feed_valid = feed_pipe_reg[RD_LAT-1];
    assign busy       = (state_reg != IDLE);
    assign A_wr_en    = 1'b0;
    assign B_wr_en    = 1'b0;
    assign C_wr_en    = (state_reg == WRITE) && row_ok;
    assign C_index    = (state_reg == WRITE) ? c_index_raw : '0;
    assign c_row_sel  = (state_reg == WRITE) ? row : '0;

endmodule

// File: tb/tb_tpu_tile_sched.sv
// Scoreboard bench for tpu_tile_sched: a tile-loop reference model queues expected
// feed and C-write events; a negedge monitor pops and compares them.
module tb_tpu_tile_sched;

    localparam int TP  = 4;
    localparam int TRD = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  K = '0;
    logic [7:0]  M = '0;
    logic [7:0]  N = '0;
    logic        busy;
    logic        A_wr_en;
    logic [15:0] A_index;
    logic        B_wr_en;
    logic [15:0] B_index;
    logic        pe_clear;
    logic        feed_valid;
    logic        C_wr_en;
    logic [15:0] C_index;
    logic [1:0]  c_row_sel;

    always #5 clk = ~clk;

    tpu_tile_sched dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .K          (K),
        .M          (M),
        .N          (N),
        .busy       (busy),
        .A_wr_en    (A_wr_en),
        .A_index    (A_index),
        .B_wr_en    (B_wr_en),
        .B_index    (B_index),
        .pe_clear   (pe_clear),
        .feed_valid (feed_valid),
        .C_wr_en    (C_wr_en),
        .C_index    (C_index),
        .c_row_sel  (c_row_sel)
    );

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
    } feed_t;

    typedef struct packed {
        logic [15:0] idx;
        logic [1:0]  row;
    } wr_t;

    feed_t       feed_q[$];
    wr_t         wr_q[$];
    int          total = 0;
    int          bad = 0;
    int          busy_cnt = 0;
    int          clear_cnt = 0;
    logic [15:0] prev_a = '0;
    logic [15:0] prev_b = '0;

    task automatic check(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", name, actual, expected, $time);
        end
    endtask

    // Reference: enumerate tiles and push every read pair and every unmasked row write.
    task automatic build_expect(input int k, input int m, input int n,
                                output int busy_exp, output int clr_exp);
        int mtn;
        int ntn;
        feed_t fe;
        wr_t   we;
        clr_exp = 0;
        if (k == 0 || m == 0 || n == 0) begin
            busy_exp = 1;
            return;
        end
        mtn = (m + TP - 1) / TP;
        ntn = (n + TP - 1) / TP;
        for (int nt = 0; nt < ntn; nt++) begin
            for (int mt = 0; mt < mtn; mt++) begin
                clr_exp++;
                for (int kk = 0; kk < k; kk++) begin
                    fe.a = 16'(mt * k + kk);
                    fe.b = 16'(nt * k + kk);
                    feed_q.push_back(fe);
                end
                for (int r = 0; r < TP; r++) begin
                    if (mt * TP + r < m) begin
                        we.idx = 16'(nt * m + mt * TP + r);
                        we.row = 2'(r);
                        wr_q.push_back(we);
                    end
                end
            end
        end
        busy_exp = 1 + mtn * ntn * (1 + k + 2 * TP - 2 + TRD + TP);
    endtask

    always @(negedge clk) begin : monitor
        feed_t fe;
        wr_t   we;
        if (rst_n) begin
            if (busy) busy_cnt++;
            if (pe_clear) clear_cnt++;
            if (feed_valid) begin
                if (feed_q.size() == 0) begin
                    check("unexpected_feed_valid", 1, 0);
                end else begin
                    fe = feed_q.pop_front();
                    check("A_index", int'(prev_a), int'(fe.a));
                    check("B_index", int'(prev_b), int'(fe.b));
                end
            end
            if (C_wr_en) begin
                if (wr_q.size() == 0) begin
                    check("unexpected_C_wr_en", 1, 0);
                end else begin
                    we = wr_q.pop_front();
                    check("C_index", int'(C_index), int'(we.idx));
                    check("c_row_sel", int'(c_row_sel), int'(we.row));
                end
            end
            if (A_wr_en || B_wr_en) check("AB_wr_en", 1, 0);
            prev_a = A_index;
            prev_b = B_index;
        end
    end

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_pe_clear"}, int'(pe_clear), 0);
        check({tag, "_feed_valid"}, int'(feed_valid), 0);
        check({tag, "_C_wr_en"}, int'(C_wr_en), 0);
        check({tag, "_C_index"}, int'(C_index), 0);
        check({tag, "_c_row_sel"}, int'(c_row_sel), 0);
        check({tag, "_A_index"}, int'(A_index), 0);
        check({tag, "_B_index"}, int'(B_index), 0);
    endtask

    // Caller is just past a negedge; returns just past the negedge of the first idle cycle.
    task automatic run_job(input int k, input int m, input int n, input bit pulse);
        int busy_exp;
        int clr_exp;
        int i;
        build_expect(k, m, n, busy_exp, clr_exp);
        busy_cnt  = 0;
        clear_cnt = 0;
        K = 8'(k);
        M = 8'(m);
        N = 8'(n);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        K = 8'($urandom);
        M = 8'($urandom);
        N = 8'($urandom);
        for (i = 0; i < 20000; i++) begin
            if (!busy) break;
            in_valid = pulse && (i == 3);
            @(negedge clk);
        end
        in_valid = 1'b0;
        #1;
        check("busy_end", int'(busy), 0);
        check("busy_cycles", busy_cnt, busy_exp);
        check("pe_clear_count", clear_cnt, clr_exp);
        check("feed_left", feed_q.size(), 0);
        check("write_left", wr_q.size(), 0);
        feed_q.delete();
        wr_q.delete();
        $display("job K=%0d M=%0d N=%0d pulse=%0d busy=%0d/%0d clears=%0d/%0d",
                 k, m, n, pulse, busy_cnt, busy_exp, clear_cnt, clr_exp);
    endtask

    initial begin
        int bexp;
        int cexp;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        #1;

        run_job(4, 4, 4, 1'b0);
        run_job(2, 6, 4, 1'b0);
        run_job(3, 4, 8, 1'b0);
        run_job(0, 4, 4, 1'b0);
        run_job(4, 4, 4, 1'b1);
        run_job(1, 5, 3, 1'b0);
        run_job(5, 1, 1, 1'b0);

        for (int j = 0; j < 14; j++) begin
            int g;
            g = int'($urandom_range(0, 2));
            repeat (g) begin
                @(negedge clk);
                #1;
            end
            if ($urandom_range(0, 7) == 0)
                run_job(int'($urandom_range(0, 1)) * int'($urandom_range(1, 9)),
                        int'($urandom_range(0, 12)), int'($urandom_range(0, 12)), 1'b0);
            else
                run_job(int'($urandom_range(1, 9)), int'($urandom_range(1, 12)),
                        int'($urandom_range(1, 12)), j[0]);
        end

        // Abort a job mid-drain with an asynchronous reset
        build_expect(8, 8, 8, bexp, cexp);
        K = 8'd8;
        M = 8'd8;
        N = 8'd8;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (12) @(negedge clk);
        #1;
        check("pre_abort_busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check_zero("abort");
        feed_q.delete();
        wr_q.delete();
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        check("post_abort_busy", int'(busy), 0);
        $display("abort K=8 M=8 N=8 during drain, expected %0d busy cycles not reached", bexp);

        run_job(int'($urandom_range(1, 9)), int'($urandom_range(1, 12)),
                int'($urandom_range(1, 12)), 1'b0);
        run_job(8, 8, 8, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
